rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader_pkg.sv | 25 ++
 rtl/rom_loader_byte_packer.sv | 49 ++++
 rtl/rom_loader.sv | 143 ++++++++++++++
 tb/tb_rom_loader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared definitions for the boot ROM loader: ROM geometry, FSM state encoding
// and the word-address helper used by both ROM ports.
package rom_loader_pkg;

  localparam int ROM_AW = 20;
  localparam logic [ROM_AW-1:0] ROM_LEN = 20'h10000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_VERIFY,
    ST_DONE,
    ST_ERR
  } state_e;

  // Byte address of word idx; wraps modulo 2^ROM_AW.
  function automatic logic [ROM_AW-1:0] word_addr(input logic [ROM_AW-1:0] base,
                                                  input logic [ROM_AW-1:0] idx);
    return base + {idx[ROM_AW-3:0], 2'b00};
  endfunction

endpackage

// File: rtl/rom_loader_byte_packer.sv
// Assembles an LSB-first byte stream into 32-bit words using a 2-bit lane
// counter; flags the transfer that completes each word.
module byte_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byte_fire_i,
  input  logic [7:0]  byte_data_i,
  output logic [31:0] word_o,
  output logic [31:0] word_next_o,
  output logic        word_done_o
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; that is what keeps always_comb from inferring a latch.
  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    if (clear_i) begin
      lane_d = 2'd0;
      word_d = '0;
    end else if (byte_fire_i) begin
      word_d[{lane_q, 3'b000} +: 8] = byte_data_i;
      lane_d = lane_q + 2'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lane_q <= 2'd0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

  // word_next_o lets the caller capture a header/checksum word on the very
  // edge its last byte arrives.
  assign word_o      = word_q;
  assign word_next_o = word_d;
  assign word_done_o = byte_fire_i && !clear_i && (lane_q == 2'd3);

endmodule

// File: rtl/rom_loader.sv
// Boot ROM loader: receives length/payload/checksum over a byte stream, writes
// the payload to ROM, reads it back and releases the core only if both sums match.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [ROM_AW-1:0] BASE_ADDR = 20'h00000,
  parameter logic [ROM_AW-1:0] MAX_BYTES = ROM_LEN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              rom_wr_en_o,
  output logic [ROM_AW-1:0] rom_wr_addr_o,
  output logic [31:0]       rom_wr_data_o,
  output logic              rom_rd_en_o,
  output logic [ROM_AW-1:0] rom_rd_addr_o,
  input  logic [31:0]       rom_rd_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              core_hold_o
);

  state_e            state_q, state_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       csum_q, csum_d;
  logic [31:0]       stream_sum_q, stream_sum_d;
  logic [31:0]       rb_sum_q, rb_sum_d;
  logic [ROM_AW-1:0] k_q, k_d, k_inc, cur_addr;
  logic              ready, pk_clear, pk_done, last_word, len_bad, wr_en, rd_en;
  logic [31:0]       pk_word, pk_next;

  assign ready     = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign k_inc     = k_q + 1'b1;
  assign last_word = ({10'b0, k_inc, 2'b00} == len_q);
  assign len_bad   = (pk_next == 32'd0) || (pk_next[1:0] != 2'b00) ||
                     (pk_next > {12'b0, MAX_BYTES});
  assign cur_addr  = word_addr(BASE_ADDR, k_q);

  byte_packer u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (pk_clear),
    .byte_fire_i (byte_valid_i && ready),
    .byte_data_i (byte_data_i),
    .word_o      (pk_word),
    .word_next_o (pk_next),
    .word_done_o (pk_done)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    csum_d       = csum_q;
    stream_sum_d = stream_sum_q;
    rb_sum_d     = rb_sum_q;
    k_d          = k_q;
    pk_clear     = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d      = ST_HDR;
          pk_clear     = 1'b1;
          len_d        = '0;
          csum_d       = '0;
          stream_sum_d = '0;
          rb_sum_d     = '0;
          k_d          = '0;
        end
      end
      ST_HDR: begin
        if (pk_done) begin
          len_d   = pk_next;
          state_d = len_bad ? ST_ERR : ST_DATA;
        end
      end
      ST_DATA: begin
        if (pk_done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en        = 1'b1;
        stream_sum_d = stream_sum_q + pk_word;
        k_d          = k_inc;
        state_d      = last_word ? ST_CSUM : ST_DATA;
      end
      ST_CSUM: begin
        if (pk_done) begin
          csum_d  = pk_next;
          k_d     = '0;
          state_d = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        rd_en    = 1'b1;
        rb_sum_d = rb_sum_q + rom_rd_data_i;
        k_d      = k_inc;
        if (last_word) begin
          state_d = ((stream_sum_q == csum_q) && (rb_sum_d == csum_q)) ? ST_DONE : ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      csum_q       <= '0;
      stream_sum_q <= '0;
      rb_sum_q     <= '0;
      k_q          <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      csum_q       <= csum_d;
      stream_sum_q <= stream_sum_d;
      rb_sum_q     <= rb_sum_d;
      k_q          <= k_d;
    end
  end

  // Outputs are gated by reset combinationally, so a WRITE cycle that coincides
  // with reset never reaches the ROM and the core is held immediately.
  always_comb begin
    byte_ready_o  = ready && rst_i;
    rom_wr_en_o   = wr_en && rst_i;
    rom_wr_addr_o = (wr_en && rst_i) ? cur_addr : '0;
    rom_wr_data_o = (wr_en && rst_i) ? pk_word : '0;
    rom_rd_en_o   = rd_en && rst_i;
    rom_rd_addr_o = (rd_en && rst_i) ? cur_addr : '0;
    busy_o        = rst_i && (state_q inside {ST_HDR, ST_DATA, ST_WRITE, ST_CSUM, ST_VERIFY});
    done_o        = rst_i && (state_q == ST_DONE);
    err_o         = rst_i && (state_q == ST_ERR);
    core_hold_o   = !rst_i || (state_q != ST_DONE);
  end

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: header decision table, directed
// multi-cycle scenarios and random sessions against a stream-level model.
module tb_rom_loader;

  localparam logic [19:0] BASE   = 20'h00000;
  localparam logic [19:0] MAXB20 = 20'h10000;
  localparam logic [31:0] MAXB   = {12'b0, MAXB20};

  logic        clk_i, rst_i, start_i, byte_valid_i, byte_ready_o;
  logic [7:0]  byte_data_i;
  logic        rom_wr_en_o, rom_rd_en_o, busy_o, done_o, err_o, core_hold_o;
  logic [19:0] rom_wr_addr_o, rom_rd_addr_o;
  logic [31:0] rom_wr_data_o, rom_rd_data_i;

  rom_loader #(.BASE_ADDR(BASE), .MAX_BYTES(MAXB20)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .byte_valid_i  (byte_valid_i),
    .byte_data_i   (byte_data_i),
    .byte_ready_o  (byte_ready_o),
    .rom_wr_en_o   (rom_wr_en_o),
    .rom_wr_addr_o (rom_wr_addr_o),
    .rom_wr_data_o (rom_wr_data_o),
    .rom_rd_en_o   (rom_rd_en_o),
    .rom_rd_addr_o (rom_rd_addr_o),
    .rom_rd_data_i (rom_rd_data_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .core_hold_o   (core_hold_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] len;
    bit          exp_err;
  } hdr_vec_t;

  hdr_vec_t    hdr_tab [8];
  logic [7:0]  tx_q [$];
  logic [19:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [19:0] rd_addr_q [$];
  logic [31:0] rom_mem [0:255];
  bit          corrupt_en;
  int          viol_cnt = 0;
  int          n_checks = 0;
  int          n_err = 0;
  int          last_sent;

  assign rom_rd_data_i = rom_mem[rom_rd_addr_o[9:2]];

  // ROM model plus port-protocol monitor, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (rom_wr_en_o) begin
      wr_addr_q.push_back(rom_wr_addr_o);
      wr_data_q.push_back(rom_wr_data_o);
      rom_mem[rom_wr_addr_o[9:2]] <= (corrupt_en && rom_wr_addr_o == BASE) ?
                                     (rom_wr_data_o ^ 32'h1) : rom_wr_data_o;
    end
    if (rom_rd_en_o) rd_addr_q.push_back(rom_rd_addr_o);
    if ((rom_wr_en_o && rom_rd_en_o) || (rom_wr_en_o && byte_ready_o) ||
        (!rom_wr_en_o && (rom_wr_addr_o != 20'd0 || rom_wr_data_o != 32'd0)) ||
        (!rom_rd_en_o && rom_rd_addr_o != 20'd0) ||
        ((int'(busy_o) + int'(done_o) + int'(err_o)) > 1))
      viol_cnt <= viol_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tx_q.push_back(w[8*i +: 8]);
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
  endtask

  // mode 0: valid always high, 1: toggles every cycle, 2: random gaps.
  task automatic send_bytes(input int first, input int count, input int mode);
    int  sent;
    int  cyc;
    logic v, xfer;
    sent = 0;
    cyc  = 0;
    while (sent < count && cyc < 2000 && !(done_o || err_o)) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      byte_valid_i = v;
      byte_data_i  = v ? tx_q[first + sent] : 8'($urandom);
      xfer = v && byte_ready_o;
      tick();
      if (xfer) sent++;
      cyc++;
    end
    byte_valid_i = 1'b0;
    last_sent = sent;
    check("send_budget", 32'(cyc < 2000), 32'd1);
  endtask

  task automatic run_session(input string name, input int mode, input bit mid_start,
                             input bit corrupt);
    logic [31:0] len, csum, sum, rb, w, w0;
    bit          hdr_bad, exp_done;
    int          nw, cyc, vbase, ln;
    len     = {tx_q[3], tx_q[2], tx_q[1], tx_q[0]};
    hdr_bad = (len == 0) || (len % 4 != 0) || (len > MAXB);
    nw      = hdr_bad ? 0 : int'(len / 4);
    ln      = 4 * nw;
    sum     = 0;
    w0      = 0;
    for (int k = 0; k < nw; k++) begin
      w = {tx_q[4+4*k+3], tx_q[4+4*k+2], tx_q[4+4*k+1], tx_q[4+4*k]};
      if (k == 0) w0 = w;
      sum += w;
    end
    csum     = hdr_bad ? 32'd0 : {tx_q[4+ln+3], tx_q[4+ln+2], tx_q[4+ln+1], tx_q[4+ln]};
    rb       = corrupt ? (sum - w0 + (w0 ^ 32'h1)) : sum;
    exp_done = !hdr_bad && (sum == csum) && (rb == csum);

    clear_logs();
    corrupt_en = corrupt;
    vbase      = viol_cnt;
    pulse_start();
    check({name, ".busy_after_start"}, 32'(busy_o), 32'd1);
    check({name, ".hold_after_start"}, 32'(core_hold_o), 32'd1);
    if (mid_start) begin
      send_bytes(0, 10, mode);
      pulse_start();
      check({name, ".start_ignored"}, {30'b0, busy_o, err_o}, 32'b10);
      send_bytes(10, tx_q.size() - 10, mode);
    end else begin
      send_bytes(0, tx_q.size(), mode);
      if (hdr_bad) check({name, ".hdr_bytes_used"}, last_sent, 32'd4);
    end
    cyc = 0;
    while (!(done_o || err_o) && cyc < 400) begin
      tick();
      cyc++;
    end
    check({name, ".ended"}, 32'(done_o || err_o), 32'd1);
    check({name, ".done"}, 32'(done_o), 32'(exp_done));
    check({name, ".err"}, 32'(err_o), 32'(!exp_done));
    check({name, ".hold"}, 32'(core_hold_o), 32'(!exp_done));
    check({name, ".busy_end"}, 32'(busy_o), 32'd0);
    check({name, ".n_writes"}, wr_addr_q.size(), nw);
    for (int k = 0; k < nw && k < wr_addr_q.size(); k++) begin
      w = {tx_q[4+4*k+3], tx_q[4+4*k+2], tx_q[4+4*k+1], tx_q[4+4*k]};
      check($sformatf("%s.wr_addr%0d", name, k), 32'(wr_addr_q[k]), 32'(BASE + 20'(4 * k)));
      check($sformatf("%s.wr_data%0d", name, k), wr_data_q[k], w);
    end
    check({name, ".n_reads"}, rd_addr_q.size(), nw);
    for (int k = 0; k < nw && k < rd_addr_q.size(); k++)
      check($sformatf("%s.rd_addr%0d", name, k), 32'(rd_addr_q[k]), 32'(BASE + 20'(4 * k)));
    check({name, ".protocol"}, viol_cnt - vbase, 32'd0);
  endtask

  task automatic build_s32(input logic [31:0] c);
    tx_q.delete();
    push_word(32'd8);
    push_word(32'h0000_0013);
    push_word(32'h0010_0093);
    push_word(c);
  endtask

  initial begin
    rst_i        = 1'b0;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    corrupt_en   = 1'b0;
    hdr_tab[0] = '{32'h0000_0006, 1'b1};
    hdr_tab[1] = '{32'h0000_0000, 1'b1};
    hdr_tab[2] = '{32'h0001_0004, 1'b1};
    hdr_tab[3] = '{32'h0001_0000, 1'b0};
    hdr_tab[4] = '{32'h0000_0008, 1'b0};
    hdr_tab[5] = '{32'h8000_0000, 1'b1};
    hdr_tab[6] = '{32'h0000_0003, 1'b1};
    hdr_tab[7] = '{32'h0000_0004, 1'b0};

    // Reset state: everything low except core_hold_o.
    tick();
    tick();
    check("rst.outs", {26'b0, busy_o, done_o, err_o, byte_ready_o, rom_wr_en_o, rom_rd_en_o}, 32'd0);
    check("rst.hold", 32'(core_hold_o), 32'd1);
    rst_i = 1'b1;
    byte_valid_i = 1'b1;
    tick();
    tick();
    tick();
    check("idle.no_start_ready", {30'b0, byte_ready_o, busy_o}, 32'd0);
    check("idle.hold", 32'(core_hold_o), 32'd1);
    byte_valid_i = 1'b0;

    // Header decision table.
    for (int i = 0; i < 8; i++) begin
      tx_q.delete();
      push_word(hdr_tab[i].len);
      clear_logs();
      pulse_start();
      send_bytes(0, 4, 0);
      check($sformatf("hdr%0d.err", i), 32'(err_o), 32'(hdr_tab[i].exp_err));
      check($sformatf("hdr%0d.ready", i), 32'(byte_ready_o), 32'(!hdr_tab[i].exp_err));
      check($sformatf("hdr%0d.busy", i), 32'(busy_o), 32'(!hdr_tab[i].exp_err));
      tick();
      check($sformatf("hdr%0d.no_write", i), wr_addr_q.size(), 32'd0);
      do_reset();
    end

    // Reference stream, then the same stream with a wrong checksum.
    build_s32(32'h0010_00A6);
    run_session("s32", 0, 1'b0, 1'b0);
    check("s32.w0", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hDEAD, 32'h0000_0013);
    check("s32.w1", wr_data_q.size() > 1 ? wr_data_q[1] : 32'hDEAD, 32'h0010_0093);
    build_s32(32'h0000_0000);
    run_session("bad_csum", 0, 1'b0, 1'b0);
    build_s32(32'h0010_00A6);
    run_session("toggle", 1, 1'b0, 1'b0);
    run_session("mid_start", 0, 1'b1, 1'b0);
    run_session("rom_corrupt", 0, 1'b0, 1'b1);

    // Reset one cycle after the 6th payload byte.
    clear_logs();
    pulse_start();
    send_bytes(0, 10, 0);
    check("rst6.writes_before", wr_addr_q.size(), 32'd1);
    rst_i = 1'b0;
    #1;
    check("rst6.outs_in_reset", {26'b0, busy_o, done_o, err_o, byte_ready_o, rom_wr_en_o, rom_rd_en_o}, 32'd0);
    check("rst6.hold_in_reset", 32'(core_hold_o), 32'd1);
    tick();
    rst_i = 1'b1;
    byte_valid_i = 1'b1;
    tick();
    tick();
    check("rst6.idle", {28'b0, busy_o, done_o, err_o, byte_ready_o}, 32'd0);
    byte_valid_i = 1'b0;
    tick();
    check("rst6.writes_after", wr_addr_q.size(), 32'd1);
    run_session("reload", 0, 1'b0, 1'b0);

    // Reset landing on the WRITE cycle must suppress that write.
    clear_logs();
    pulse_start();
    send_bytes(0, 8, 0);
    check("rstw.write_visible", 32'(rom_wr_en_o), 32'd1);
    rst_i = 1'b0;
    #1;
    check("rstw.write_gated", 32'(rom_wr_en_o), 32'd0);
    tick();
    rst_i = 1'b1;
    tick();
    check("rstw.no_write", wr_addr_q.size(), 32'd0);
    run_session("reload2", 2, 1'b0, 1'b0);

    // Random sessions.
    for (int s = 0; s < 8; s++) begin
      int          nwords, mode;
      bit          good, corr;
      logic [31:0] sum, w;
      nwords = $urandom_range(1, 12);
      mode   = $urandom_range(0, 2);
      good   = ($urandom_range(0, 3) != 0);
      corr   = ($urandom_range(0, 7) == 0);
      sum    = 0;
      tx_q.delete();
      push_word(32'(4 * nwords));
      for (int k = 0; k < nwords; k++) begin
        w = $urandom;
        push_word(w);
        sum += w;
      end
      push_word(good ? sum : $urandom);
      run_session($sformatf("rnd%0d", s), mode, (nwords >= 2) && ($urandom_range(0, 1) == 1), corr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
